// File: rtl/bp_cce_mem_mux_pkg.sv
// Shared definitions for the multi-CCE memory command/response mux.
// Optional build macro: BP_CCE_MEM_MUX_PERF_EN (performance counters on the top).
package bp_cce_mem_mux_pkg;

   localparam int perf_cnt_w_lp = 32;

   typedef logic [perf_cnt_w_lp-1:0] perf_cnt_t;

   // Width of a channel index; a single channel still needs one bit of storage.
   function automatic int tag_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/bp_cce_mem_mux_if.sv
// Bus bundle between the CCE instances / memory network and bp_cce_mem_mux.
// slave: the mux itself; master: the surrounding CCEs and memory port.
interface bp_cce_mem_mux_if
  #(parameter int num_cce_p       = 2,
    parameter int mem_msg_width_p = 128);

   logic [num_cce_p*mem_msg_width_p-1:0] mem_cmd_i;
   logic [num_cce_p-1:0]                 mem_cmd_v_i;
   logic [num_cce_p-1:0]                 mem_cmd_ready_o;

   logic [mem_msg_width_p-1:0]           mem_cmd_o;
   logic                                 mem_cmd_v_o;
   logic                                 mem_cmd_ready_i;

   logic [mem_msg_width_p-1:0]           mem_resp_i;
   logic                                 mem_resp_v_i;
   logic                                 mem_resp_yumi_o;

   logic [mem_msg_width_p-1:0]           mem_resp_o;
   logic [num_cce_p-1:0]                 mem_resp_v_o;
   logic [num_cce_p-1:0]                 mem_resp_yumi_i;

   modport slave (
      input  mem_cmd_i, mem_cmd_v_i, mem_cmd_ready_i,
      input  mem_resp_i, mem_resp_v_i, mem_resp_yumi_i,
      output mem_cmd_ready_o, mem_cmd_o, mem_cmd_v_o,
      output mem_resp_yumi_o, mem_resp_o, mem_resp_v_o
   );

   modport master (
      output mem_cmd_i, mem_cmd_v_i, mem_cmd_ready_i,
      output mem_resp_i, mem_resp_v_i, mem_resp_yumi_i,
      input  mem_cmd_ready_o, mem_cmd_o, mem_cmd_v_o,
      input  mem_resp_yumi_o, mem_resp_o, mem_resp_v_o
   );

endinterface

// File: rtl/bp_cce_mem_rr_arb.sv
// Round-robin arbiter: picks the first requester at or after the pointer,
// and moves the pointer past the winner only when the grant is consumed.
module bp_cce_mem_rr_arb
   import bp_cce_mem_mux_pkg::*;
  #(parameter  int num_req_p = 2,
    localparam int idx_w_lp  = tag_width(num_req_p))
   (input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic [num_req_p-1:0] reqs_i,
    input  logic                 advance_i,
    output logic [num_req_p-1:0] grant_o,
    output logic [idx_w_lp-1:0]  grant_idx_o);

   logic [idx_w_lp-1:0] rr_ptr_r;
   logic [idx_w_lp-1:0] rr_ptr_n;

   // Scan once around the ring starting at the pointer, first requester wins
   always_comb begin
      int                  cand;
      logic [idx_w_lp-1:0] cand_idx;
      logic                found;
      grant_o     = '0;
      grant_idx_o = '0;
      found       = 1'b0;
      cand        = 0;
      cand_idx    = '0;
      for (int k = 0; k < num_req_p; k++) begin
         cand = int'(rr_ptr_r) + k;
         if (cand >= num_req_p)
            cand = cand - num_req_p;
         cand_idx = idx_w_lp'(cand);
         if (!found && reqs_i[cand_idx]) begin
            found             = 1'b1;
            grant_o[cand_idx] = 1'b1;
            grant_idx_o       = cand_idx;
         end
      end
   end

   // One past the winner, wrapping; with a single channel this stays at 0
   always_comb begin
      rr_ptr_n = '0;
      if (grant_idx_o != idx_w_lp'(num_req_p - 1))
         rr_ptr_n = grant_idx_o + idx_w_lp'(1);
   end

   // Pointer only moves on a consumed grant
   always_ff @(posedge clk_i) begin
      if (reset_i)
         rr_ptr_r <= '0;
      else if (advance_i)
         rr_ptr_r <= rr_ptr_n;
   end

endmodule

// File: rtl/bp_cce_mem_mux.sv
// Merges the mem_cmd streams of several CCEs onto one memory port and steers
// in-order memory responses back to the CCE that issued each command.
// Optional build macro: BP_CCE_MEM_MUX_PERF_EN adds issue_cnt_o / full_stall_cnt_o.
module bp_cce_mem_mux
   import bp_cce_mem_mux_pkg::*;
  #(parameter int num_cce_p         = 2,
    parameter int mem_msg_width_p   = 128,
    parameter int max_outstanding_p = 8)
   (input  logic                  clk_i,
    input  logic                  reset_i,
    bp_cce_mem_mux_if.slave       mem_if
`ifdef BP_CCE_MEM_MUX_PERF_EN
    ,
    output logic [num_cce_p*perf_cnt_w_lp-1:0] issue_cnt_o,
    output logic [perf_cnt_w_lp-1:0]           full_stall_cnt_o
`endif
   );

   localparam int tag_w_lp = tag_width(num_cce_p);
   localparam int ptr_w_lp = $clog2(max_outstanding_p);
   localparam int cnt_w_lp = $clog2(max_outstanding_p + 1);

   function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
      return (p == ptr_w_lp'(max_outstanding_p - 1)) ? '0 : p + ptr_w_lp'(1);
   endfunction

   logic [num_cce_p-1:0]       buf_full_p0;
   logic [mem_msg_width_p-1:0] buf_data_p0 [num_cce_p];
   logic [num_cce_p-1:0]       capture;
   logic [num_cce_p-1:0]       drain;
   logic [num_cce_p-1:0]       grant;
   logic [tag_w_lp-1:0]        grant_idx;
   logic                       issue;

   logic [tag_w_lp-1:0]        tag_mem [max_outstanding_p];
   logic [ptr_w_lp-1:0]        tag_wr_ptr;
   logic [ptr_w_lp-1:0]        tag_rd_ptr;
   logic [cnt_w_lp-1:0]        tag_cnt;
   logic                       tag_full;
   logic                       tag_empty;
   logic [tag_w_lp-1:0]        tag_head;
   logic                       resp_sel;
   logic                       tag_pop;

   // ---- stage p0: per-channel one-entry input buffers ----
   assign mem_if.mem_cmd_ready_o = reset_i ? '0 : ~buf_full_p0;
   assign capture                = mem_if.mem_cmd_v_i & mem_if.mem_cmd_ready_o;
   assign drain                  = issue ? grant : '0;

   // Full flags: set on capture, cleared when the arbiter sends the entry out
   always_ff @(posedge clk_i) begin
      if (reset_i)
         buf_full_p0 <= '0;
      else
         buf_full_p0 <= (buf_full_p0 & ~drain) | capture;
   end

   // Payload registers carry no reset; the full flag qualifies them
   always_ff @(posedge clk_i) begin
      for (int i = 0; i < num_cce_p; i++)
         if (capture[i])
            buf_data_p0[i] <= mem_if.mem_cmd_i[i*mem_msg_width_p +: mem_msg_width_p];
   end

   // ---- issue: round-robin across full buffers toward memory ----
   bp_cce_mem_rr_arb #(.num_req_p(num_cce_p)) u_arb (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .reqs_i      (buf_full_p0),
      .advance_i   (issue),
      .grant_o     (grant),
      .grant_idx_o (grant_idx)
   );

   // Full tag FIFO blocks issue even if a response pops it this cycle
   assign issue              = ~reset_i & mem_if.mem_cmd_ready_i & ~tag_full & (|buf_full_p0);
   assign mem_if.mem_cmd_v_o = issue;

   // One-hot grant selects the winning buffer's payload
   always_comb begin
      mem_if.mem_cmd_o = '0;
      for (int i = 0; i < num_cce_p; i++)
         if (grant[i])
            mem_if.mem_cmd_o = mem_if.mem_cmd_o | buf_data_p0[i];
   end

   // ---- tag FIFO: owner of every command still awaiting its response ----
   assign tag_full  = (tag_cnt == cnt_w_lp'(max_outstanding_p));
   assign tag_empty = (tag_cnt == '0);
   assign tag_head  = tag_mem[tag_rd_ptr];

   // Pointers and occupancy; simultaneous push and pop leave the count alone
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         tag_wr_ptr <= '0;
         tag_rd_ptr <= '0;
         tag_cnt    <= '0;
      end else begin
         if (issue)
            tag_wr_ptr <= ptr_inc(tag_wr_ptr);
         if (tag_pop)
            tag_rd_ptr <= ptr_inc(tag_rd_ptr);
         if (issue && !tag_pop)
            tag_cnt <= tag_cnt + cnt_w_lp'(1);
         else if (!issue && tag_pop)
            tag_cnt <= tag_cnt - cnt_w_lp'(1);
      end
   end

   // Tag storage written with the granted channel index
   always_ff @(posedge clk_i) begin
      if (issue)
         tag_mem[tag_wr_ptr] <= grant_idx;
   end

   // ---- response: route to the oldest outstanding owner ----
   assign resp_sel               = ~reset_i & mem_if.mem_resp_v_i & ~tag_empty;
   assign mem_if.mem_resp_o      = mem_if.mem_resp_i;
   assign mem_if.mem_resp_yumi_o = |(mem_if.mem_resp_yumi_i & mem_if.mem_resp_v_o);
   assign tag_pop                = mem_if.mem_resp_yumi_o;

   // Valid goes only to the head owner; nothing is presented with no tags held
   always_comb begin
      mem_if.mem_resp_v_o = '0;
      if (resp_sel)
         mem_if.mem_resp_v_o[tag_head] = 1'b1;
   end

`ifndef SYNTHESIS
   // A response with nothing outstanding means memory broke the in-order contract
   resp_without_tag_a : assert property (@(posedge clk_i) disable iff (reset_i)
      !(mem_if.mem_resp_v_i && tag_empty));
`endif

`ifdef BP_CCE_MEM_MUX_PERF_EN
   perf_cnt_t issue_cnt_r [num_cce_p];
   perf_cnt_t full_stall_cnt_r;

   function automatic perf_cnt_t sat_inc(input perf_cnt_t c);
      return (c == '1) ? c : c + perf_cnt_t'(1);
   endfunction

   // Saturating per-channel issue counts and tag-full stall cycles
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         for (int i = 0; i < num_cce_p; i++)
            issue_cnt_r[i] <= '0;
         full_stall_cnt_r <= '0;
      end else begin
         for (int i = 0; i < num_cce_p; i++)
            if (drain[i])
               issue_cnt_r[i] <= sat_inc(issue_cnt_r[i]);
         if ((|buf_full_p0) && mem_if.mem_cmd_ready_i && tag_full)
            full_stall_cnt_r <= sat_inc(full_stall_cnt_r);
      end
   end

   // Flatten the per-channel counters onto the output bus
   always_comb begin
      issue_cnt_o = '0;
      for (int i = 0; i < num_cce_p; i++)
         issue_cnt_o[i*perf_cnt_w_lp +: perf_cnt_w_lp] = issue_cnt_r[i];
   end

   assign full_stall_cnt_o = full_stall_cnt_r;
`endif

endmodule

// File: tb/tb_bp_cce_mem_mux.sv
// Self-checking bench for bp_cce_mem_mux (2 channels, 128-bit messages, 8 outstanding).
// Optional build macro: BP_CCE_MEM_MUX_PERF_EN also checks the performance counters.
module tb_bp_cce_mem_mux;
   import bp_cce_mem_mux_pkg::*;

   localparam int N    = 2;
   localparam int W    = 128;
   localparam int MAXO = 8;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   bp_cce_mem_mux_if #(.num_cce_p(N), .mem_msg_width_p(W)) mem_if ();

`ifdef BP_CCE_MEM_MUX_PERF_EN
   logic [N*32-1:0] issue_cnt;
   logic [31:0]     full_stall_cnt;
`endif

   bp_cce_mem_mux #(.num_cce_p(N), .mem_msg_width_p(W), .max_outstanding_p(MAXO)) dut (
      .clk_i            (clk),
      .reset_i          (reset),
      .mem_if           (mem_if)
`ifdef BP_CCE_MEM_MUX_PERF_EN
      ,
      .issue_cnt_o      (issue_cnt),
      .full_stall_cnt_o (full_stall_cnt)
`endif
   );

   int checks   = 0;
   int failures = 0;

   // reference model state, driven only by the behavioural rules
   bit          m_full [N];
   logic [W-1:0] m_data [N];
   int          m_rr;
   int          m_tags [$];
   int unsigned m_issue [N];
   int unsigned m_stall;

   // snapshot of DUT outputs for the current cycle
   logic [N-1:0] o_ready, o_resp_v;
   logic         o_cmd_v, o_yumi;
   logic [W-1:0] o_cmd, o_resp;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [W-1:0] rand_msg();
      logic [W-1:0] r;
      r = '0;
      for (int k = 0; k < W/32; k++)
         r = {r[W-33:0], 32'($urandom())};
      return r;
   endfunction

   // random payloads whose low byte names the source channel
   function automatic logic [N*W-1:0] rand_cmd();
      logic [N*W-1:0] c;
      logic [W-1:0]   m;
      c = '0;
      for (int i = 0; i < N; i++) begin
         m      = rand_msg();
         m[7:0] = 8'(i);
         c[i*W +: W] = m;
      end
      return c;
   endfunction

   // One clock: drive inputs after negedge, check against the model, advance the model.
   task automatic cycle(input logic rst, input logic [N-1:0] v, input logic [N*W-1:0] cd,
                        input logic rdy, input logic rv, input logic [W-1:0] rd,
                        input logic [N-1:0] ry);
      logic [N-1:0] e_ready, e_resp_v;
      logic         e_cmd_v, e_yumi;
      int           g;
      @(negedge clk);
      reset                  = rst;
      mem_if.mem_cmd_v_i     = v;
      mem_if.mem_cmd_i       = cd;
      mem_if.mem_cmd_ready_i = rdy;
      mem_if.mem_resp_v_i    = rv;
      mem_if.mem_resp_i      = rd;
      mem_if.mem_resp_yumi_i = ry;
      #1;
      o_ready  = mem_if.mem_cmd_ready_o;
      o_cmd_v  = mem_if.mem_cmd_v_o;
      o_cmd    = mem_if.mem_cmd_o;
      o_resp_v = mem_if.mem_resp_v_o;
      o_resp   = mem_if.mem_resp_o;
      o_yumi   = mem_if.mem_resp_yumi_o;

      g = -1;
      for (int k = 0; k < N; k++) begin
         int c;
         c = (m_rr + k) % N;
         if (g < 0 && m_full[c]) g = c;
      end
      for (int i = 0; i < N; i++) e_ready[i] = !rst && !m_full[i];
      e_cmd_v  = !rst && rdy && (m_tags.size() < MAXO) && (g >= 0);
      e_resp_v = '0;
      e_yumi   = 1'b0;
      if (!rst && rv && m_tags.size() > 0) begin
         e_resp_v[m_tags[0]] = 1'b1;
         e_yumi              = ry[m_tags[0]];
      end

      check("ready_o", W'(o_ready), W'(e_ready));
      check("cmd_v_o", W'(o_cmd_v), W'(e_cmd_v));
      if (e_cmd_v) check("cmd_o", o_cmd, m_data[g]);
      check("resp_v_o", W'(o_resp_v), W'(e_resp_v));
      check("resp_o", o_resp, rd);
      check("resp_yumi_o", W'(o_yumi), W'(e_yumi));

      if (rst) begin
         for (int i = 0; i < N; i++) begin m_full[i] = 0; m_issue[i] = 0; end
         m_rr = 0;
         m_tags.delete();
         m_stall = 0;
      end else begin
         if (g >= 0 && rdy && m_tags.size() == MAXO) m_stall++;
         if (e_cmd_v) begin
            m_full[g] = 0;
            m_tags.push_back(g);
            m_rr = (g + 1) % N;
            m_issue[g]++;
         end
         if (e_yumi) void'(m_tags.pop_front());
         for (int i = 0; i < N; i++)
            if (v[i] && e_ready[i]) begin
               m_full[i] = 1;
               m_data[i] = cd[i*W +: W];
            end
      end
   endtask

   task automatic cyc(input logic rst, input logic [N-1:0] v, input logic rdy,
                      input logic rv, input logic [N-1:0] ry);
      cycle(rst, v, rand_cmd(), rdy, rv, rand_msg(), ry);
   endtask

   // let the register update of the last cycle land before reading counters
   task automatic settle();
      @(posedge clk);
      #1;
   endtask

   task automatic check_perf(input string tag);
`ifdef BP_CCE_MEM_MUX_PERF_EN
      for (int i = 0; i < N; i++)
         check($sformatf("%s_issue_cnt%0d", tag, i), W'(issue_cnt[i*32 +: 32]), W'(m_issue[i]));
      check($sformatf("%s_full_stall_cnt", tag), W'(full_stall_cnt), W'(m_stall));
`else
      if (tag.len() < 0) $display("%s", tag);
`endif
   endtask

   typedef struct {
      logic         rst;
      logic [N-1:0] v;
      logic         rdy;
      logic         rv;
      logic [N-1:0] ry;
      logic [N-1:0] e_ready;
      logic         e_cmd_v;
      logic [N-1:0] e_resp_v;
      logic         e_yumi;
      int           e_grant;
   } vec_t;

   vec_t tbl [16];

   initial begin
      logic [W-1:0]   a, b, c, r1, r2, r3;
      logic [N*W-1:0] cd;
      int sent, issued, stall_obs;
      int per_ch [N];

      reset = 1'b1;
      mem_if.mem_cmd_v_i = '0; mem_if.mem_cmd_i = '0; mem_if.mem_cmd_ready_i = 1'b0;
      mem_if.mem_resp_v_i = 1'b0; mem_if.mem_resp_i = '0; mem_if.mem_resp_yumi_i = '0;
      for (int i = 0; i < N; i++) begin m_full[i] = 0; m_data[i] = '0; m_issue[i] = 0; end
      m_rr = 0; m_stall = 0;

      //          rst v     rdy rv ry     ready cv rv_o  y  grant
      tbl[0]  = '{1, 2'b11, 1, 0, 2'b00, 2'b00, 0, 2'b00, 0, -1};
      tbl[1]  = '{1, 2'b11, 1, 0, 2'b00, 2'b00, 0, 2'b00, 0, -1};
      tbl[2]  = '{1, 2'b11, 1, 0, 2'b00, 2'b00, 0, 2'b00, 0, -1};
      tbl[3]  = '{0, 2'b11, 0, 0, 2'b00, 2'b11, 0, 2'b00, 0, -1};
      tbl[4]  = '{0, 2'b11, 1, 0, 2'b00, 2'b00, 1, 2'b00, 0,  0};
      tbl[5]  = '{0, 2'b11, 1, 0, 2'b00, 2'b01, 1, 2'b00, 0,  1};
      tbl[6]  = '{0, 2'b11, 1, 0, 2'b00, 2'b10, 1, 2'b00, 0,  0};
      tbl[7]  = '{0, 2'b11, 1, 0, 2'b00, 2'b01, 1, 2'b00, 0,  1};
      tbl[8]  = '{0, 2'b00, 0, 1, 2'b11, 2'b10, 0, 2'b01, 1, -1};
      tbl[9]  = '{0, 2'b00, 0, 1, 2'b00, 2'b10, 0, 2'b10, 0, -1};
      tbl[10] = '{0, 2'b00, 0, 1, 2'b10, 2'b10, 0, 2'b10, 1, -1};
      tbl[11] = '{0, 2'b00, 0, 1, 2'b01, 2'b10, 0, 2'b01, 1, -1};
      tbl[12] = '{0, 2'b00, 0, 1, 2'b01, 2'b10, 0, 2'b10, 0, -1};
      tbl[13] = '{0, 2'b00, 0, 1, 2'b10, 2'b10, 0, 2'b10, 1, -1};
      tbl[14] = '{0, 2'b00, 1, 0, 2'b00, 2'b10, 1, 2'b00, 0,  0};
      tbl[15] = '{0, 2'b00, 0, 1, 2'b01, 2'b11, 0, 2'b01, 1, -1};

      // reset hold, fairness and in-order routing
      for (int r = 0; r < 16; r++) begin
         cyc(tbl[r].rst, tbl[r].v, tbl[r].rdy, tbl[r].rv, tbl[r].ry);
         check($sformatf("tbl%0d_ready", r), W'(o_ready), W'(tbl[r].e_ready));
         check($sformatf("tbl%0d_cmd_v", r), W'(o_cmd_v), W'(tbl[r].e_cmd_v));
         check($sformatf("tbl%0d_resp_v", r), W'(o_resp_v), W'(tbl[r].e_resp_v));
         check($sformatf("tbl%0d_yumi", r), W'(o_yumi), W'(tbl[r].e_yumi));
         if (tbl[r].e_grant >= 0)
            check($sformatf("tbl%0d_grant", r), W'(o_cmd[7:0]), W'(tbl[r].e_grant));
      end

      // ordering: A on ch1, B on ch0, C on ch1, responses in command order
      cyc(1, 2'b00, 0, 0, 2'b00);
      a = rand_msg(); b = rand_msg(); c = rand_msg();
      r1 = rand_msg(); r2 = rand_msg(); r3 = rand_msg();
      cd = rand_cmd(); cd[W +: W] = a;
      cycle(0, 2'b10, cd, 1, 0, rand_msg(), 2'b00);
      check("ord_idle_v", W'(o_cmd_v), W'(1'b0));
      cd = rand_cmd(); cd[0 +: W] = b;
      cycle(0, 2'b01, cd, 1, 0, rand_msg(), 2'b00);
      check("ord_A", o_cmd, a);
      cd = rand_cmd(); cd[W +: W] = c;
      cycle(0, 2'b10, cd, 1, 0, rand_msg(), 2'b00);
      check("ord_B", o_cmd, b);
      cycle(0, 2'b00, rand_cmd(), 1, 0, rand_msg(), 2'b00);
      check("ord_C", o_cmd, c);
      cycle(0, 2'b00, rand_cmd(), 0, 1, r1, 2'b11);
      check("ord_rv1", W'(o_resp_v), W'(2'b10));
      check("ord_rd1", o_resp, r1);
      cycle(0, 2'b00, rand_cmd(), 0, 1, r2, 2'b11);
      check("ord_rv2", W'(o_resp_v), W'(2'b01));
      check("ord_rd2", o_resp, r2);
      cycle(0, 2'b00, rand_cmd(), 0, 1, r3, 2'b11);
      check("ord_rv3", W'(o_resp_v), W'(2'b10));
      check("ord_rd3", o_resp, r3);

      // tag FIFO full: 9 commands, no responses
      cyc(1, 2'b00, 0, 0, 2'b00);
      sent = 0; issued = 0; stall_obs = 0;
      for (int i = 0; i < N; i++) per_ch[i] = 0;
      for (int t = 0; t < 24; t++) begin
         logic [N-1:0] v;
         int pre_issued, pre_sent;
         v = '0;
         for (int i = 0; i < N; i++)
            if (!m_full[i] && sent < 9) begin v[i] = 1'b1; sent++; end
         pre_issued = issued;
         pre_sent   = sent - $countones(v);
         cyc(0, v, 1, 0, 2'b00);
         if (o_cmd_v === 1'b1) begin
            issued++;
            per_ch[o_cmd[7:0] % N]++;
         end
         if (pre_issued == MAXO && pre_sent == 9 && o_cmd_v === 1'b0) stall_obs++;
      end
      check("full_issued", W'(issued), W'(MAXO));
      check("full_held_v", W'(o_cmd_v), W'(1'b0));
      cyc(0, 2'b00, 1, 1, 2'b11);
      check("full_pop_yumi", W'(o_yumi), W'(1'b1));
      check("full_no_bypass", W'(o_cmd_v), W'(1'b0));
      stall_obs++;
      cyc(0, 2'b00, 1, 0, 2'b00);
      check("full_ninth_issues", W'(o_cmd_v), W'(1'b1));
      if (o_cmd_v === 1'b1) per_ch[o_cmd[7:0] % N]++;
      settle();
`ifdef BP_CCE_MEM_MUX_PERF_EN
      check("perf_stall_obs", W'(full_stall_cnt), W'(stall_obs));
      for (int i = 0; i < N; i++)
         check($sformatf("perf_issue_obs%0d", i), W'(issue_cnt[i*32 +: 32]), W'(per_ch[i]));
`endif
      check_perf("full");

      // backpressure: pointer parked at 1, both buffers full for 5 cycles
      cyc(1, 2'b00, 0, 0, 2'b00);
      cyc(0, 2'b11, 0, 0, 2'b00);
      cyc(0, 2'b00, 1, 0, 2'b00);
      check("bp_first_grant", W'(o_cmd[7:0]), W'(0));
      cyc(0, 2'b01, 0, 0, 2'b00);
      for (int t = 0; t < 5; t++) begin
         cyc(0, 2'b11, 0, 0, 2'b00);
         check($sformatf("bp%0d_cmd_v", t), W'(o_cmd_v), W'(1'b0));
         check($sformatf("bp%0d_ready", t), W'(o_ready), W'(2'b00));
      end
      cyc(0, 2'b00, 1, 0, 2'b00);
      check("bp_release_v", W'(o_cmd_v), W'(1'b1));
      check("bp_release_ch1", W'(o_cmd[7:0]), W'(1));
      cyc(0, 2'b00, 1, 0, 2'b00);
      check("bp_then_ch0", W'(o_cmd[7:0]), W'(0));

      // randomized traffic against the model, with occasional mid-run resets
      cyc(1, 2'b00, 0, 0, 2'b00);
      for (int t = 0; t < 3000; t++) begin
         logic rst, rdy, rv;
         rst = ($urandom_range(0, 199) == 0);
         rdy = ($urandom_range(0, 3) != 0);
         rv  = (m_tags.size() > 0) && ($urandom_range(0, 2) == 0);
         cyc(rst, N'($urandom()), rdy, rv, N'($urandom()));
      end
      settle();
      check_perf("rand");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
